// File: rtl/full_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_if
// Description : Operand/result bundle for the registered full adder. The
//               master drives operands and consumes results; the adder is
//               the slave. The ovf wire exists only when FULL_ADDER_OVF_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface full_adder_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             in_valid;
  logic [WIDTH-1:0] Y;
  logic             Cout;
  logic             out_valid;
`ifdef FULL_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output A, B, Cin, in_valid,
    input  Y, Cout, out_valid, ovf
  );

  modport slave (
    input  A, B, Cin, in_valid,
    output Y, Cout, out_valid, ovf
  );
`else
  modport master (
    output A, B, Cin, in_valid,
    input  Y, Cout, out_valid
  );

  modport slave (
    input  A, B, Cin, in_valid,
    output Y, Cout, out_valid
  );
`endif
endinterface
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : Registered ripple-carry adder, {Cout,Y} = A + B + Cin with a
//               one-cycle latency. WIDTH=1 is the classic full-adder cell.
//               Optional macro FULL_ADDER_OVF_EN adds a registered signed
//               overflow flag (ovf = c[WIDTH] ^ c[WIDTH-1]).
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder #(
  parameter int WIDTH = 1
) (
  input  wire          clk,
  input  wire          rst_n,
  full_adder_if.slave  bus
);

  // Carry chain: w_carry[0] is the external carry-in, w_carry[WIDTH] the carry-out.
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  logic [WIDTH-1:0] r_y;
  logic             r_cout;
  logic             r_valid;

  assign w_carry[0] = bus.Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign w_sum[i]       = bus.A[i] ^ bus.B[i] ^ w_carry[i];
    assign w_carry[i + 1] = (bus.A[i] & bus.B[i]) |
                            (bus.A[i] & w_carry[i]) |
                            (bus.B[i] & w_carry[i]);
  end

  // Capture sum/carry only on qualified cycles so X on idle operands never lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y     <= '0;
      r_cout  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_y    <= w_sum;
        r_cout <= w_carry[WIDTH];
      end
    end
  end

  assign bus.Y         = r_y;
  assign bus.Cout      = r_cout;
  assign bus.out_valid = r_valid;

`ifdef FULL_ADDER_OVF_EN
  logic r_ovf;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (bus.in_valid) begin
      r_ovf <= w_carry[WIDTH] ^ w_carry[WIDTH - 1];
    end
  end

  assign bus.ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_full_adder
// Description : Self-checking bench for full_adder. Drives a WIDTH=1 and a
//               WIDTH=8 instance in parallel and compares against an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_full_adder;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_errors;

  full_adder_if #(.WIDTH(1)) bus1 ();
  full_adder_if #(.WIDTH(8)) bus8 ();

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: what each output register should hold.
  logic [7:0] exp_y8;
  logic       exp_c8;
  logic       exp_o8;
  logic       exp_y1;
  logic       exp_c1;
  logic       exp_o1;
  logic       exp_v;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check($sformatf("%s_v8", tag), {31'd0, bus8.out_valid}, {31'd0, exp_v});
    check($sformatf("%s_y8", tag), {24'd0, bus8.Y}, {24'd0, exp_y8});
    check($sformatf("%s_c8", tag), {31'd0, bus8.Cout}, {31'd0, exp_c8});
    check($sformatf("%s_v1", tag), {31'd0, bus1.out_valid}, {31'd0, exp_v});
    check($sformatf("%s_y1", tag), {31'd0, bus1.Y}, {31'd0, exp_y1});
    check($sformatf("%s_c1", tag), {31'd0, bus1.Cout}, {31'd0, exp_c1});
`ifdef FULL_ADDER_OVF_EN
    check($sformatf("%s_o8", tag), {31'd0, bus8.ovf}, {31'd0, exp_o8});
    check($sformatf("%s_o1", tag), {31'd0, bus1.ovf}, {31'd0, exp_o1});
`endif
  endtask

  task automatic model_reset();
    exp_y8 = '0; exp_c8 = 1'b0; exp_o8 = 1'b0;
    exp_y1 = 1'b0; exp_c1 = 1'b0; exp_o1 = 1'b0;
    exp_v  = 1'b0;
  endtask

  // Present one cycle of stimulus to both adders, advance one edge, compare.
  task automatic step(input logic v, input logic [7:0] a8, input logic [7:0] b8,
                      input logic c8, input logic a1, input logic b1, input logic c1,
                      input string tag);
    int s8, ss8, s1, ss1;
    if (v) begin
      bus8.A = a8; bus8.B = b8; bus8.Cin = c8;
      bus1.A = a1; bus1.B = b1; bus1.Cin = c1;
      s8  = int'(a8) + int'(b8) + int'(c8);
      ss8 = int'($signed(a8)) + int'($signed(b8)) + int'(c8);
      exp_y8 = s8[7:0];
      exp_c8 = s8[8];
      exp_o8 = (ss8 > 127) || (ss8 < -128);
      s1  = int'(a1) + int'(b1) + int'(c1);
      ss1 = (a1 ? -1 : 0) + (b1 ? -1 : 0) + int'(c1);
      exp_y1 = s1[0];
      exp_c1 = s1[1];
      exp_o1 = (ss1 > 0) || (ss1 < -1);
    end else begin
      bus8.A = 'x; bus8.B = 'x; bus8.Cin = 1'bx;
      bus1.A = 'x; bus1.B = 'x; bus1.Cin = 1'bx;
    end
    bus8.in_valid = v;
    bus1.in_valid = v;
    exp_v = v;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  logic [1:0] fa_table [8];

  initial begin
    n_checks = 0;
    n_errors = 0;
    fa_table[0] = 2'b00; fa_table[1] = 2'b01; fa_table[2] = 2'b01; fa_table[3] = 2'b10;
    fa_table[4] = 2'b01; fa_table[5] = 2'b10; fa_table[6] = 2'b10; fa_table[7] = 2'b11;

    rst_n = 1'b0;
    bus8.A = '0; bus8.B = '0; bus8.Cin = 1'b0; bus8.in_valid = 1'b0;
    bus1.A = '0; bus1.B = '0; bus1.Cin = 1'b0; bus1.in_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Exhaustive 1-bit truth table, back to back.
    for (int k = 0; k < 8; k++) begin
      logic [2:0] abc;
      abc = 3'(k);
      step(1'b1, 8'(k * 37), 8'(k * 11), abc[0], abc[2], abc[1], abc[0], $sformatf("fa%0d", k));
      check($sformatf("fa_tbl%0d", k), {30'd0, bus1.Cout, bus1.Y}, {30'd0, fa_table[k]});
    end

    // Hold: result stays, out_valid drops, idle operands are X.
    step(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, "hold_load");
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "hold_idle");
    check("hold_y1_const", {31'd0, bus1.Y}, 32'd1);
    check("hold_c1_const", {31'd0, bus1.Cout}, 32'd1);
    check("hold_v_const", {31'd0, bus1.out_valid}, 32'd0);

    // 8-bit boundaries.
    step(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, "wrap");
    check("wrap_y8_const", {24'd0, bus8.Y}, 32'h00);
    check("wrap_c8_const", {31'd0, bus8.Cout}, 32'd1);
    step(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, "sovf");
    check("sovf_y8_const", {24'd0, bus8.Y}, 32'h80);
    step(1'b1, 8'h80, 8'h80, 1'b1, 1'b1, 1'b1, 1'b0, "negovf");

    // Asynchronous reset mid-cycle clears outputs before the next edge.
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    rst_n = 1'b1;
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "post_rst_idle");

    // Reset collision: input presented while reset is held is dropped.
    step(1'b1, 8'h12, 8'h34, 1'b1, 1'b1, 1'b0, 1'b1, "pre_coll");
    rst_n = 1'b0;
    bus8.A = 8'h55; bus8.B = 8'h66; bus8.Cin = 1'b1; bus8.in_valid = 1'b1;
    bus1.A = 1'b1; bus1.B = 1'b1; bus1.Cin = 1'b1; bus1.in_valid = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    check_all("coll");
    rst_n = 1'b1;
    step(1'b1, 8'hA5, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, "post_coll");

    // Randomized traffic, mostly back to back with occasional idle cycles.
    for (int k = 0; k < 300; k++) begin
      logic [31:0] r;
      r = $urandom;
      step(($urandom_range(0, 3) != 0), r[7:0], r[15:8], r[16], r[17], r[18], r[19],
           $sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
